// File: rtl/axi_lite_master_bridge_if.sv
// AXI4-Lite channel bundle between the LSU bridge (master) and the Sram slave.
// Signal names match the Sram S_AXI_* ports one-for-one.
interface axi_lite_master_bridge_if;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [63:0] M_AXI_WDATA;
  logic [7:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [63:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding AXI4-Lite master: one LSU request becomes AR/R or AW/W/B traffic plus a one-cycle rsp pulse.
// Optional wait-state abort is enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_lite_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  axi_lite_master_bridge_if.master m_axi
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef AXI_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef AXI_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_wen ? S_AW_W : S_AR;
        end
      end
      S_AR: begin
        if (m_axi.M_AXI_ARREADY) state_d = S_R;
      end
      S_R: begin
        if (m_axi.M_AXI_RVALID) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axi.M_AXI_RDATA;
          rsp_err_d   = (m_axi.M_AXI_RRESP != 2'b00);
          state_d     = S_IDLE;
        end
      end
      S_AW_W: begin
        // A ready seen after its own channel finished is harmless: the done flag is already set.
        aw_done_d = aw_done_q | m_axi.M_AXI_AWREADY;
        w_done_d  = w_done_q | m_axi.M_AXI_WREADY;
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: begin
        if (m_axi.M_AXI_BVALID) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = (m_axi.M_AXI_BRESP != 2'b00);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    // Counter restarts on every state change; expiry overrides any handshake in the same cycle.
    cnt_d = (state_q == S_IDLE || state_d != state_q) ? '0 : cnt_q + 1'b1;
    if (state_q != S_IDLE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      state_d     = S_IDLE;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
      cnt_d       = '0;
    end
`endif
  end

  // Valids and readies decode registered state only, so they never follow a ready combinationally.
  always_comb begin
    req_ready           = (state_q == S_IDLE);
    m_axi.M_AXI_ARVALID = (state_q == S_AR);
    m_axi.M_AXI_RREADY  = (state_q == S_R);
    m_axi.M_AXI_AWVALID = (state_q == S_AW_W) && !aw_done_q;
    m_axi.M_AXI_WVALID  = (state_q == S_AW_W) && !w_done_q;
    m_axi.M_AXI_BREADY  = (state_q == S_B);
    m_axi.M_AXI_ARADDR  = addr_q;
    m_axi.M_AXI_AWADDR  = addr_q;
    m_axi.M_AXI_WDATA   = wdata_q;
    m_axi.M_AXI_WSTRB   = wstrb_q;
    rsp_valid           = rsp_valid_q;
    rsp_err             = rsp_err_q;
    rsp_rdata           = rsp_rdata_q;
  end

endmodule
